// File: rtl/cache_ctrl_wb_if.sv
// cache_ctrl_wb bus bundle: CPU word port plus line-wide memory port.
// master = requester/memory side, slave = the cache controller.
interface cache_ctrl_wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8
);
    logic                             cpu_req;
    logic                             cpu_we;
    logic [ADDR_WIDTH-1:0]            cpu_addr;
    logic [DATA_WIDTH-1:0]            cpu_wdata;
    logic                             cpu_ready;
    logic                             cpu_done;
    logic [DATA_WIDTH-1:0]            cpu_rdata;
    logic                             cpu_hit;
    logic                             mem_req;
    logic                             mem_we;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata;
    logic                             mem_ack;
    logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata, cpu_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );
endinterface

// File: rtl/cache_ctrl_wb.sv
// Set-associative write-back/write-allocate cache controller.
// Age-based LRU per set, dirty victim writeback before line refill.
module cache_ctrl_wb #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 16,
    parameter int LINE_WORDS    = 8,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cache_ctrl_wb_if.slave           bus,
    output logic [COUNTER_WIDTH-1:0] hit_count,
    output logic [COUNTER_WIDTH-1:0] miss_count
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_ALLOCATE  = 3'd4;
    localparam logic [2:0] S_RESPOND   = 3'd5;

    typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [WAY_W-1:0]      way_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_req_q;

    logic [TAG_W-1:0] tag_mem  [NUM_SETS][NUM_WAYS];
    line_t            data_mem [NUM_SETS][NUM_WAYS];
    logic             valid    [NUM_SETS][NUM_WAYS];
    logic             dirty    [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] age      [NUM_SETS][NUM_WAYS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign off = req_addr[OFF_W-1:0];
    assign idx = req_addr[OFF_W +: IDX_W];
    assign tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;

    // Tag match over valid ways; victim is lowest invalid way, else oldest.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (age[idx][w] == WAY_W'(NUM_WAYS - 1))
                victim = WAY_W'(w);
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid[idx][w])
                victim = WAY_W'(w);
        for (int w = 0; w < NUM_WAYS; w++)
            if (valid[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    logic                  access;
    logic [WAY_W-1:0]      acc_way;
    logic [DATA_WIDTH-1:0] acc_rdata;
    logic                  refill_ack;

    assign access     = (state == S_LOOKUP && hit) || state == S_ALLOCATE;
    assign acc_way    = (state == S_LOOKUP) ? hit_way : way_q;
    assign acc_rdata  = req_we ? req_wdata : data_mem[idx][acc_way][off];
    assign refill_ack = state == S_REFILL && mem_req_q && bus.mem_ack;

    assign bus.cpu_ready = state == S_IDLE;
    assign bus.cpu_done  = state == S_RESPOND;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_hit   = hit_q && state == S_RESPOND;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = state == S_WRITEBACK;

    // Memory address/line held by state and registered request fields.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state == S_WRITEBACK) begin
            bus.mem_addr  = {tag_mem[idx][way_q], idx, {OFF_W{1'b0}}};
            bus.mem_wdata = data_mem[idx][way_q];
        end else if (state == S_REFILL) begin
            bus.mem_addr = {tag, idx, {OFF_W{1'b0}}};
        end
    end

    // Control FSM, request capture, memory request and statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            way_q      <= '0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        req_addr  <= bus.cpu_addr;
                        req_we    <= bus.cpu_we;
                        req_wdata <= bus.cpu_wdata;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        way_q   <= hit_way;
                        hit_q   <= 1'b1;
                        rdata_q <= acc_rdata;
                        if (hit_count != '1)
                            hit_count <= hit_count + 1'b1;
                        state <= S_RESPOND;
                    end else begin
                        way_q     <= victim;
                        hit_q     <= 1'b0;
                        mem_req_q <= 1'b1;
                        if (miss_count != '1)
                            miss_count <= miss_count + 1'b1;
                        if (valid[idx][victim] && dirty[idx][victim])
                            state <= S_WRITEBACK;
                        else
                            state <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    rdata_q <= acc_rdata;
                    state   <= S_RESPOND;
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Valid/dirty bookkeeping and LRU age update on every access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= WAY_W'(w);
                end
        end else begin
            if (refill_ack) begin
                valid[idx][way_q] <= 1'b1;
                dirty[idx][way_q] <= 1'b0;
            end
            if (access) begin
                if (req_we)
                    dirty[idx][acc_way] <= 1'b1;
                for (int w = 0; w < NUM_WAYS; w++)
                    if (WAY_W'(w) == acc_way)
                        age[idx][w] <= '0;
                    else if (age[idx][w] < age[idx][acc_way])
                        age[idx][w] <= age[idx][w] + 1'b1;
            end
        end
    end

    // Line/tag storage: refill writes whole line, accesses merge one word.
    always_ff @(posedge clk) begin
        if (refill_ack) begin
            data_mem[idx][way_q] <= bus.mem_rdata;
            tag_mem[idx][way_q]  <= tag;
        end else if (access && req_we) begin
            data_mem[idx][acc_way][off] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: misses, hits, writeback,
// LRU victim choice, reset abort and counter saturation.
module tb_cache_ctrl_wb;
    logic clk;
    logic reset_n;
    logic [15:0] hc1, mc1;
    logic [3:0]  hc2, mc2;
    int tests = 0;
    int fails = 0;

    cache_ctrl_wb_if bus ();
    cache_ctrl_wb_if bus2 ();

    assign bus2.cpu_req   = bus.cpu_req;
    assign bus2.cpu_we    = bus.cpu_we;
    assign bus2.cpu_addr  = bus.cpu_addr;
    assign bus2.cpu_wdata = bus.cpu_wdata;
    assign bus2.mem_ack   = bus.mem_ack;
    assign bus2.mem_rdata = bus.mem_rdata;

    cache_ctrl_wb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .hit_count  (hc1),
        .miss_count (mc1)
    );

    cache_ctrl_wb #(.COUNTER_WIDTH(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus2.slave),
        .hit_count  (hc2),
        .miss_count (mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        chk("cpu_ready", bus.cpu_ready, 1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic wait_mem(input logic we, input logic [31:0] addr);
        int n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req", bus.mem_req, 1);
        chk("mem_we", bus.mem_we, we);
        chk("mem_addr", bus.mem_addr, addr);
    endtask

    task automatic ack(input int dly, input logic [31:0] base);
        repeat (dly) @(negedge clk);
        chk("mem_req_held", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 8; i++)
            bus.mem_rdata[i*32 +: 32] = base + 32'(i);
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic done_chk(input logic [31:0] rd, input logic hit);
        @(negedge clk);
        chk("cpu_done", bus.cpu_done, 1);
        chk("cpu_rdata", bus.cpu_rdata, rd);
        chk("cpu_hit", bus.cpu_hit, hit);
    endtask

    task automatic hit_acc(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd);
        issue(we, addr, wd);
        chk("no_mem_req", bus.mem_req, 0);
        done_chk(rd, 1'b1);
    endtask

    task automatic miss_read(input logic [31:0] addr, input logic [31:0] base);
        issue(1'b0, addr, 32'h0);
        chk("lookup_no_req", bus.mem_req, 0);
        wait_mem(1'b0, addr & ~32'h7);
        ack(1, base);
        done_chk(base + (addr & 32'h7), 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.cpu_ready, 1);
        chk("rst_done", bus.cpu_done, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_hits", hc1, 0);
        chk("rst_misses", mc1, 0);
        chk("rst_hits4", hc2, 0);
        reset_n = 1'b1;

        // Cold read 0x100, ack three cycles after request rises.
        issue(1'b0, 32'h100, 32'h0);
        wait_mem(1'b0, 32'h100);
        ack(3, 32'hA0);
        done_chk(32'hA0, 1'b0);
        chk("t1_misses", mc1, 1);

        hit_acc(1'b0, 32'h102, 32'h0, 32'hA2);
        chk("t2_hits", hc1, 1);

        hit_acc(1'b1, 32'h103, 32'hDEADBEEF, 32'hDEADBEEF);
        miss_read(32'h180, 32'hB0);
        miss_read(32'h200, 32'hC0);
        miss_read(32'h280, 32'hD0);

        // Dirty 0x100 line is oldest: writeback, gap, then refill.
        issue(1'b0, 32'h300, 32'h0);
        wait_mem(1'b1, 32'h100);
        chk("wb_word3", bus.mem_wdata[3*32 +: 32], 32'hDEADBEEF);
        chk("wb_word0", bus.mem_wdata[0 +: 32], 32'hA0);
        ack(2, 32'h0);
        chk("wb_gap", bus.mem_req, 0);
        wait_mem(1'b0, 32'h300);
        ack(0, 32'hE0);
        done_chk(32'hE0, 1'b0);
        chk("t3_hits", hc1, 2);
        chk("t3_misses", mc1, 5);

        // Make 0x180 dirty and oldest, then evict it; reset mid writeback.
        hit_acc(1'b1, 32'h182, 32'h12345678, 32'h12345678);
        hit_acc(1'b0, 32'h200, 32'h0, 32'hC0);
        hit_acc(1'b0, 32'h280, 32'h0, 32'hD0);
        hit_acc(1'b0, 32'h300, 32'h0, 32'hE0);
        issue(1'b0, 32'h380, 32'h0);
        wait_mem(1'b1, 32'h180);
        chk("wb2_word2", bus.mem_wdata[2*32 +: 32], 32'h12345678);
        chk("wb2_word0", bus.mem_wdata[0 +: 32], 32'hB0);
        reset_n = 1'b0;
        #1;
        chk("async_mem_req", bus.mem_req, 0);
        chk("async_done", bus.cpu_done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", bus.cpu_done, 0);
        end
        reset_n = 1'b1;
        chk("post_rst_ready", bus.cpu_ready, 1);
        chk("post_rst_hits", hc1, 0);

        // Refill set 0 clean; hit 0x100 so 0x180 becomes the victim.
        miss_read(32'h100, 32'hA0);
        miss_read(32'h180, 32'hB0);
        miss_read(32'h200, 32'hC0);
        miss_read(32'h280, 32'hD0);
        hit_acc(1'b0, 32'h101, 32'h0, 32'hA1);
        miss_read(32'h300, 32'hE0);
        hit_acc(1'b0, 32'h200, 32'h0, 32'hC0);
        miss_read(32'h181, 32'hB0);
        chk("t4_hits", hc1, 2);
        chk("t4_misses", mc1, 6);

        // Saturation of the 4-bit counter while the 16-bit one keeps counting.
        for (int i = 0; i < 17; i++) begin
            hit_acc(1'b0, 32'h100, 32'h0, 32'hA0);
            chk("hits4_sat", hc2, (i + 3 > 15) ? 15 : i + 3);
        end
        chk("hits16", hc1, 19);
        chk("misses4", mc2, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_wb.md
Name: cache_ctrl_wb

Overview:
- Parametrised set-associative, write-back, write-allocate cache controller. Successor to the single-level way/lookup controller.
- Owns tag, valid, dirty and data storage plus per-set age-based LRU. Serves one CPU word request at a time.
- Talks to main memory through a line-wide request/acknowledge handshake, with dirty-victim writeback before refill.

Parameters:
- ADDR_WIDTH, 32, word address width of cpu_addr.
- DATA_WIDTH, 32, CPU word width.
- NUM_WAYS, 4, associativity; power of two, >=2.
- NUM_SETS, 16, sets; power of two, >=2.
- LINE_WORDS, 8, words per line; power of two, >=2.
- COUNTER_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  request valid; accepted when cpu_req && cpu_ready at posedge
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ready  out  1  controller idle, can accept
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_done
- cpu_hit  out  1  with cpu_done: 1=hit, 0=miss
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1=line writeback, 0=line refill
- mem_addr  out  ADDR_WIDTH  line word address (offset bits zero)
- mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line, word 0 in LSBs
- mem_ack  in  1  memory completion; refill data valid this cycle
- mem_rdata  in  LINE_WORDS*DATA_WIDTH  refill line, word 0 in LSBs
- hit_count  out  COUNTER_WIDTH  saturating hit count
- miss_count  out  COUNTER_WIDTH  saturating miss count

Behaviour:
- Address split: offset = cpu_addr[log2(LINE_WORDS)-1:0]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Reset (async):
  - state IDLE; all outputs 0 except cpu_ready=1.
  - All valid and dirty bits cleared; counters 0.
  - LRU age of way w = w in every set. Data and tag arrays are not reset.
- FSM: IDLE, LOOKUP, WRITEBACK, REFILL, ALLOCATE, RESPOND.
- IDLE: cpu_ready=1. On accept, register addr/we/wdata and go to LOOKUP. cpu_ready=0 in all other states.
- LOOKUP: compare tag against all valid ways of the set (at most one match by construction).
  - Hit: perform the access (write merges word, sets dirty), update LRU, hit_count++, go to RESPOND.
  - Miss: miss_count++ and choose the victim: lowest-index invalid way, else the way with age NUM_WAYS-1.
  - Victim valid and dirty -> WRITEBACK; else -> REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line. On mem_ack go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index, 0}. On mem_ack, write mem_rdata into the victim way, set tag, valid=1, dirty=0, go to ALLOCATE.
- ALLOCATE: perform the access on the refilled way (write merges word, dirty=1), update LRU, go to RESPOND.
- RESPOND: cpu_done=1 for exactly one cycle.
  - cpu_rdata = addressed word after any write merge.
  - cpu_hit = 1 if reached via the LOOKUP hit path, else 0.
  - Return to IDLE.
- Latency:
  - Hit: cpu_done in the 2nd cycle after the accept edge.
  - Clean miss: cpu_done 2 cycles after the refill mem_ack edge.
- Memory handshake:
  - mem_addr/mem_we/mem_wdata stable while mem_req=1.
  - mem_req drops the cycle after mem_ack, then rises again in REFILL if coming from WRITEBACK (one-cycle gap).
  - mem_ack while mem_req=0 is ignored. No timeout: waits indefinitely.
- LRU update on access to way a with old age k: age[a]=0; every way in that set with age<k increments; others unchanged. Ages remain a permutation of 0..NUM_WAYS-1.
- Counters saturate at all ones and never wrap.
- cpu_req while cpu_ready=0 is ignored; the requester holds it.
- Reset mid-operation: mem_req and cpu_done drop asynchronously. The in-flight request is discarded with no cpu_done, and the cache is left empty.

Test Plan:
1. Defaults, cold read 0x100 (index 0, tag 2):
   - Expect mem_req=1, mem_we=0, mem_addr=0x100.
   - Drive mem_ack 3 cycles later with words 0xA0..0xA7.
   - Expect cpu_done, rdata=0xA0, cpu_hit=0, miss_count=1.
2. Read 0x102:
   - Expect cpu_done 2 cycles after accept, rdata=0xA2, cpu_hit=1, hit_count=1.
   - No mem_req.
3. Write 0x103=0xDEADBEEF (hit), then read 0x180, 0x200, 0x280 (fill ways 1-3 of set 0), then read 0x300:
   - Expect WRITEBACK mem_we=1, mem_addr=0x100, mem_wdata word3=0xDEADBEEF.
   - Then refill mem_addr=0x300.
4. Fill set 0 with 0x100, 0x180, 0x200, 0x280, then read 0x100 (hit), then read 0x300:
   - Expect victim is the 0x180 line.
   - Clean victim: no writeback, refill only.
5. Assert reset_n during WRITEBACK with mem_req=1:
   - Expect mem_req=0 immediately and no cpu_done.
   - After release: cpu_ready=1; read 0x100 misses.
6. COUNTER_WIDTH=4, 17 consecutive hits:
   - Expect hit_count=15, held there.
